// File: rtl/dom_shared_sqscmul_gf4_mc.sv
// Masked multi-lane GF(4) unit: Q = X*Y ^ sqsc(X^Y) with DOM-indep remasking.
// Ports: ClkxCI/RstxBI (sync active-low), ValidxSI/TagxDI in, share buses
// _XxDI/_YxDI/_ZxDI in; ValidxSO/TagxDO/_QxDO out. Latency 1 cycle, or 2
// when DOM_SQSC_OUTREG_EN is defined (registered, glitch-free _QxDO).
module dom_shared_sqscmul_gf4_mc #(
  parameter int SHARES   = 2,
  parameter int CHANNELS = 4,
  parameter int TAG_W    = 4
) (
  input  logic                              ClkxCI,
  input  logic                              RstxBI,
  input  logic                              ValidxSI,
  input  logic [TAG_W-1:0]                  TagxDI,
  input  logic [CHANNELS*2*SHARES-1:0]      _XxDI,
  input  logic [CHANNELS*2*SHARES-1:0]      _YxDI,
  input  logic [CHANNELS*SHARES*(SHARES-1)-1:0] _ZxDI,
  output logic                              ValidxSO,
  output logic [TAG_W-1:0]                  TagxDO,
  output logic [CHANNELS*2*SHARES-1:0]      _QxDO
);

  localparam int P  = SHARES * (SHARES - 1) / 2;
  localparam int DW = CHANNELS * 2 * SHARES;

  function automatic logic [1:0] gf4_mul(
    input logic [1:0] a,
    input logic [1:0] b
  );
    gf4_mul = {(a[1] & b[1]) ^ (a[1] & b[0]) ^ (a[0] & b[1]),
               (a[1] & b[1]) ^ (a[0] & b[0])};
  endfunction

  // x*a^2 in this basis is just a bit swap
  function automatic logic [1:0] sqsc(input logic [1:0] a);
    sqsc = {a[0], a[1]};
  endfunction

  // lexicographic index of pair (lo<hi)
  function automatic int pidx(input int lo, input int hi);
    pidx = lo * SHARES - (lo * (lo + 1)) / 2 + (hi - lo - 1);
  endfunction

  // [c][i][i] holds the inner term, [c][i][j] the cross term X_i*Y_j
  logic [1:0] term_d [CHANNELS][SHARES][SHARES];
  logic [1:0] term_q [CHANNELS][SHARES][SHARES];
  logic [TAG_W-1:0] tag1_q;
  logic             vld1_q;
  logic [DW-1:0]    q1;

  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      for (int i = 0; i < SHARES; i++) begin
        for (int j = 0; j < SHARES; j++) begin
          logic [1:0] xi, yi, yj, zp;
          xi = _XxDI[(c*SHARES+i)*2 +: 2];
          yi = _YxDI[(c*SHARES+i)*2 +: 2];
          yj = _YxDI[(c*SHARES+j)*2 +: 2];
          zp = '0;
          if (i < j)
            zp = _ZxDI[(c*P+pidx(i, j))*2 +: 2];
          else if (j < i)
            zp = _ZxDI[(c*P+pidx(j, i))*2 +: 2];
          if (i == j)
            term_d[c][i][j] = gf4_mul(xi, yi) ^ sqsc(xi ^ yi);
          else
            term_d[c][i][j] = gf4_mul(xi, yj) ^ zp;
        end
      end
    end
  end

  // Terms only load on valid so idle cycles do not toggle the
  // cross-domain compression logic.
  always_ff @(posedge ClkxCI) begin
    if (!RstxBI) begin
      for (int c = 0; c < CHANNELS; c++)
        for (int i = 0; i < SHARES; i++)
          for (int j = 0; j < SHARES; j++)
            term_q[c][i][j] <= '0;
      tag1_q <= '0;
      vld1_q <= 1'b0;
    end else begin
      vld1_q <= ValidxSI;
      if (ValidxSI) begin
        for (int c = 0; c < CHANNELS; c++)
          for (int i = 0; i < SHARES; i++)
            for (int j = 0; j < SHARES; j++)
              term_q[c][i][j] <= term_d[c][i][j];
        tag1_q <= TagxDI;
      end
    end
  end

  // Share i compresses only its own registered terms
  always_comb begin
    q1 = '0;
    for (int c = 0; c < CHANNELS; c++)
      for (int i = 0; i < SHARES; i++)
        for (int j = 0; j < SHARES; j++)
          q1[(c*SHARES+i)*2 +: 2] = q1[(c*SHARES+i)*2 +: 2] ^ term_q[c][i][j];
  end

`ifdef DOM_SQSC_OUTREG_EN
  logic [DW-1:0]    q2_q;
  logic [TAG_W-1:0] tag2_q;
  logic             vld2_q;

  always_ff @(posedge ClkxCI) begin
    if (!RstxBI) begin
      q2_q   <= '0;
      tag2_q <= '0;
      vld2_q <= 1'b0;
    end else begin
      vld2_q <= vld1_q;
      if (vld1_q) begin
        q2_q   <= q1;
        tag2_q <= tag1_q;
      end
    end
  end

  assign _QxDO    = q2_q;
  assign TagxDO   = tag2_q;
  assign ValidxSO = vld2_q;
`else
  assign _QxDO    = q1;
  assign TagxDO   = tag1_q;
  assign ValidxSO = vld1_q;
`endif

endmodule

// File: tb/tb_dom_shared_sqscmul_gf4_mc.sv
// Bench for dom_shared_sqscmul_gf4_mc (3 shares, 4 lanes).
// Random sharings checked against a plain GF(4) arithmetic model.
module tb_dom_shared_sqscmul_gf4_mc;

  localparam int SH = 3;
  localparam int CH = 4;
  localparam int TW = 4;
  localparam int DW = CH * 2 * SH;
  localparam int ZW = CH * SH * (SH - 1);
`ifdef DOM_SQSC_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          v_i;
  logic          v_o;
  logic [TW-1:0] tag_i;
  logic [TW-1:0] tag_o;
  logic [DW-1:0] x_s;
  logic [DW-1:0] y_s;
  logic [DW-1:0] q_s;
  logic [ZW-1:0] z_s;

  dom_shared_sqscmul_gf4_mc #(
    .SHARES(SH), .CHANNELS(CH), .TAG_W(TW)
  ) dut (
    .ClkxCI  (clk),
    .RstxBI  (rst_n),
    .ValidxSI(v_i),
    .TagxDI  (tag_i),
    ._XxDI   (x_s),
    ._YxDI   (y_s),
    ._ZxDI   (z_s),
    .ValidxSO(v_o),
    .TagxDO  (tag_o),
    ._QxDO   (q_s)
  );

  int checks  = 0;
  int passed  = 0;
  int e       = 0;
  int lastrst = 0;

  logic            hv   [1024];
  logic [TW-1:0]   htag [1024];
  logic [2*CH-1:0] hq   [1024];

  // polynomial multiply then reduce x^2 = x + 1
  function automatic int gmul(input int a, input int b);
    int p;
    p = 0;
    for (int i = 0; i < 2; i++)
      if (((b >> i) & 1) != 0) p = p ^ (a << i);
    if ((p & 4) != 0) p = p ^ 7;
    return p & 3;
  endfunction

  function automatic int fref(input int x, input int y);
    return gmul(x, y) ^ gmul(2, gmul(x ^ y, x ^ y));
  endfunction

  function automatic logic [2*CH-1:0] recomb(input logic [DW-1:0] v);
    logic [2*CH-1:0] r;
    r = '0;
    for (int c = 0; c < CH; c++)
      for (int s = 0; s < SH; s++)
        r[c*2 +: 2] = r[c*2 +: 2] ^ v[(c*SH+s)*2 +: 2];
    return r;
  endfunction

  function automatic logic [2*CH-1:0] model(
    input logic [DW-1:0] xs,
    input logic [DW-1:0] ys
  );
    logic [2*CH-1:0] xu, yu, r;
    xu = recomb(xs);
    yu = recomb(ys);
    r = '0;
    for (int c = 0; c < CH; c++)
      r[c*2 +: 2] = 2'(fref(int'(xu[c*2 +: 2]), int'(yu[c*2 +: 2])));
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: got %0h expected %0h", nm, obs, exp);
    end
  endtask

  task automatic tick();
    int s, k;
    e++;
    hv[e]   = v_i;
    htag[e] = tag_i;
    hq[e]   = model(x_s, y_s);
    if (!rst_n) lastrst = e;
    @(posedge clk);
    #1;
    s = e - LAT + 1;
    k = 0;
    for (int j = s; j > lastrst; j--)
      if (k == 0 && hv[j]) k = j;
    chk("valid", 64'(v_o), 64'((s > lastrst) && hv[s]));
    if (k > 0) begin
      chk("tag", 64'(tag_o), 64'(htag[k]));
      chk("q", 64'(recomb(q_s)), 64'(hq[k]));
    end else begin
      chk("tag_zero", 64'(tag_o), 64'(0));
      chk("q_zero", 64'(q_s), 64'(0));
    end
  endtask

  task automatic share(input logic [2*CH-1:0] xu,
                       input logic [2*CH-1:0] yu);
    for (int c = 0; c < CH; c++) begin
      logic [1:0] ax, ay, r;
      ax = xu[c*2 +: 2];
      ay = yu[c*2 +: 2];
      for (int s = 0; s < SH - 1; s++) begin
        r = 2'($urandom);
        x_s[(c*SH+s)*2 +: 2] = r;
        ax = ax ^ r;
        r = 2'($urandom);
        y_s[(c*SH+s)*2 +: 2] = r;
        ay = ay ^ r;
      end
      x_s[(c*SH+SH-1)*2 +: 2] = ax;
      y_s[(c*SH+SH-1)*2 +: 2] = ay;
    end
    z_s = ZW'($urandom);
  endtask

  task automatic op(input logic [2*CH-1:0] xu,
                    input logic [2*CH-1:0] yu,
                    input logic [TW-1:0] t);
    v_i   = 1'b1;
    tag_i = t;
    share(xu, yu);
    tick();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      v_i   = 1'b0;
      tag_i = TW'($urandom);
      x_s   = DW'($urandom);
      y_s   = DW'($urandom);
      z_s   = ZW'($urandom);
      tick();
    end
  endtask

  initial begin
    logic [2*CH-1:0] xu, yu, rq;
    logic [DW-1:0]   snap;
    logic [1:0]      prev;
    int              changes;

    rst_n = 1'b0;
    v_i   = 1'b0;
    tag_i = '0;
    x_s   = '0;
    y_s   = '0;
    z_s   = '0;
    tick();
    tick();
    rst_n = 1'b1;
    idle(2);

    // directed unshared vectors on every lane
    op({CH{2'b10}}, {CH{2'b11}}, 4'h1);
    op({CH{2'b01}}, {CH{2'b01}}, 4'h2);
    op({CH{2'b11}}, {CH{2'b11}}, 4'h3);
    op({CH{2'b00}}, {CH{2'b10}}, 4'h4);
    idle(LAT + 1);
    chk("vec_last", 64'(recomb(q_s)), 64'({CH{2'b01}}));

    // all 16 (X,Y) pairs visit every lane
    for (int k = 0; k < 16; k++) begin
      for (int c = 0; c < CH; c++) begin
        logic [3:0] pr;
        pr = 4'((k + 4 * c) % 16);
        xu[c*2 +: 2] = pr[3:2];
        yu[c*2 +: 2] = pr[1:0];
      end
      op(xu, yu, TW'($urandom));
    end
    idle(LAT);

    // back-to-back tags 1,2,3, a bubble, then 4
    op(8'($urandom), 8'($urandom), 4'd1);
    op(8'($urandom), 8'($urandom), 4'd2);
    op(8'($urandom), 8'($urandom), 4'd3);
    idle(1);
    op(8'($urandom), 8'($urandom), 4'd4);
    idle(LAT + 1);

    // reset while a valid with tag 5 is presented
    op(8'($urandom), 8'($urandom), 4'd6);
    rst_n = 1'b0;
    v_i   = 1'b1;
    tag_i = 4'd5;
    share(8'($urandom), 8'($urandom));
    tick();
    chk("rst_valid", 64'(v_o), 64'(0));
    chk("rst_tag", 64'(tag_o), 64'(0));
    rst_n = 1'b1;
    idle(LAT + 1);

    // mask sweep on lane 0 with fixed shares
    share({CH{2'b11}}, {CH{2'b01}});
    v_i     = 1'b1;
    changes = 0;
    prev    = '0;
    for (int zz = 0; zz < 64; zz++) begin
      z_s   = ZW'(zz);
      tag_i = TW'(zz);
      tick();
      rq = recomb(q_s);
      if (zz >= LAT - 1) begin
        chk("mask_const", 64'(rq[1:0]), 64'(2'b10));
        if (zz >= LAT && q_s[1:0] != prev) changes++;
      end
      prev = q_s[1:0];
    end
    chk("mask_share_moves", 64'(changes > 0), 64'(1));

    // idle inputs must not disturb the held outputs
    idle(LAT + 1);
    snap = q_s;
    for (int i = 0; i < 10; i++) begin
      idle(1);
      chk("hold", 64'(q_s), 64'(snap));
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
